mem_stage_bus: RTL

// - Next-generation memory stage. Replaces the single-cycle, array-backed data memory with a
//   req/gnt/rvalid bus master, so wait-stated or shared memory can sit behind it.
// - Performs byte/half/word (and dword at 64b) store masking and load extraction with sign/zero extension.
// - Stalls the pipeline until each access completes. Sits between execute and writeback.

---
 rtl/mem_stage_bus.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_bus.sv
// Memory stage bus master: req/gnt/rvalid access with store lane masking and load extraction.
// Optional MEM_MISALIGN_TRAP_EN: reject misaligned ops with a misalign pulse instead of aligning.
module mem_stage_bus #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    i_clk,
  input  logic                    i_arst_n,
  input  logic                    i_op_valid,
  input  logic                    i_op_load,
  input  logic                    i_op_store,
  input  logic [2:0]              i_lsuop,
  input  logic [DATA_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic                    o_stall,
  output logic                    o_ld_valid,
  output logic [DATA_WIDTH-1:0]   o_ld_data,
  output logic                    o_bus_err,
  output logic                    o_misalign,
  output logic                    o_bus_req,
  output logic                    o_bus_we,
  output logic [DATA_WIDTH-1:0]   o_bus_addr,
  output logic [DATA_WIDTH-1:0]   o_bus_wdata,
  output logic [DATA_WIDTH/8-1:0] o_bus_mask,
  input  logic                    i_bus_gnt,
  input  logic                    i_bus_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_bus_rdata
);

  localparam int unsigned MASK_SIZE = DATA_WIDTH / 8;
  localparam int unsigned OFF_W     = $clog2(MASK_SIZE);
  localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  logic [1:0]            r_state, w_state_d;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_addr, r_wdata, r_ld_data;
  logic [MASK_SIZE-1:0]  r_mask;
  logic [OFF_W-1:0]      r_off;
  logic [1:0]            r_size;
  logic                  r_signed, r_we, r_err;

  logic [1:0]            w_size;
  logic                  w_signed, w_op, w_start, w_req, w_capture, w_to, w_timeout, w_sbit;
  logic [OFF_W-1:0]      w_off, w_low_bits, w_off_fix;
  logic [MASK_SIZE-1:0]  w_mask;
  logic [DATA_WIDTH-1:0] w_wdata, w_shift, w_keep, w_ext;

  // Unsupported encodings (D/WU at 32b, 111) fall back to a signed word.
  always_comb begin
    w_size   = SZ_W;
    w_signed = 1'b1;
    case (i_lsuop)
      3'b000:  w_size = SZ_B;
      3'b001:  w_size = SZ_H;
      3'b011:  if (DATA_WIDTH == 64) w_size = SZ_D;
      3'b100:  begin w_size = SZ_B; w_signed = 1'b0; end
      3'b101:  begin w_size = SZ_H; w_signed = 1'b0; end
      3'b110:  if (DATA_WIDTH == 64) w_signed = 1'b0;
      default: ;
    endcase
  end

  assign w_off      = i_addr[OFF_W-1:0];
  assign w_low_bits = (OFF_W'(1) << w_size) - OFF_W'(1);
  assign w_off_fix  = w_off & ~w_low_bits;
  assign w_op       = i_op_valid & (i_op_load | i_op_store);

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_aligned;
  assign w_aligned  = (w_off & w_low_bits) == '0;
  assign w_start    = w_op & w_aligned;
  assign o_misalign = (r_state == ST_IDLE) & w_op & ~w_aligned;
`else
  assign w_start    = w_op;
  assign o_misalign = 1'b0;
`endif

  always_comb begin
    case (w_size)
      SZ_B: begin
        w_mask  = MASK_SIZE'(1) << w_off_fix;
        w_wdata = {MASK_SIZE{i_wdata[7:0]}};
      end
      SZ_H: begin
        w_mask  = MASK_SIZE'(3) << w_off_fix;
        w_wdata = {(MASK_SIZE/2){i_wdata[15:0]}};
      end
      SZ_W: begin
        w_mask  = MASK_SIZE'(4'hF) << w_off_fix;
        w_wdata = {(MASK_SIZE/4){i_wdata[31:0]}};
      end
      default: begin
        w_mask  = '1;
        w_wdata = i_wdata;
      end
    endcase
  end

  // Load extraction: bring the addressed lane down, then extend above the access size.
  assign w_shift = i_bus_rdata >> {r_off, 3'b000};
  always_comb begin
    case (r_size)
      SZ_B:    begin w_keep = DATA_WIDTH'(8'hFF);         w_sbit = w_shift[7];  end
      SZ_H:    begin w_keep = DATA_WIDTH'(16'hFFFF);      w_sbit = w_shift[15]; end
      SZ_W:    begin w_keep = DATA_WIDTH'(32'hFFFF_FFFF); w_sbit = w_shift[31]; end
      default: begin w_keep = '1;                         w_sbit = 1'b0;        end
    endcase
  end
  assign w_ext = (w_shift & w_keep) | ({DATA_WIDTH{w_sbit & r_signed}} & ~w_keep);

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_d = r_state;
    w_capture = 1'b0;
    w_to      = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) w_state_d = ST_REQ;
      ST_REQ: begin
        if (i_bus_gnt && (r_we || i_bus_rvalid)) begin
          w_state_d = ST_DONE;
          w_capture = ~r_we;
        end else if (w_timeout) begin
          w_state_d = ST_DONE;
          w_to      = 1'b1;
        end else if (i_bus_gnt) begin
          w_state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_bus_rvalid) begin
          w_state_d = ST_DONE;
          w_capture = 1'b1;
        end else if (w_timeout) begin
          w_state_d = ST_DONE;
          w_to      = 1'b1;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ld_data <= '0;
      r_mask    <= '0;
      r_off     <= '0;
      r_size    <= SZ_B;
      r_signed  <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == ST_IDLE && w_start) begin
        r_addr   <= {i_addr[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        r_off    <= w_off_fix;
        r_size   <= w_size;
        r_signed <= w_signed;
        r_we     <= i_op_store;
        r_mask   <= w_mask;
        r_wdata  <= w_wdata;
        r_cnt    <= '0;
        r_err    <= 1'b0;
      end else if (r_state == ST_REQ || r_state == ST_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_capture) r_ld_data <= w_ext;
      else if (w_to) r_ld_data <= '0;
      if (w_to) r_err <= 1'b1;
    end
  end

  assign w_req       = (r_state == ST_REQ);
  assign o_stall     = ((r_state == ST_IDLE) & w_start) | w_req | (r_state == ST_WAIT);
  assign o_bus_req   = w_req;
  assign o_bus_we    = w_req & r_we;
  assign o_bus_addr  = w_req ? r_addr : '0;
  assign o_bus_wdata = w_req ? r_wdata : '0;
  assign o_bus_mask  = w_req ? r_mask : '0;
  assign o_ld_valid  = (r_state == ST_DONE) & ~r_we & ~r_err;
  assign o_bus_err   = (r_state == ST_DONE) & r_err;
  assign o_ld_data   = r_ld_data;

endmodule
